game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Game-state controller downstream of the sprite/CLUT layering stage. Consumes per-pixel
//  opaque-draw flags (frog vs. hazards), hazard respawn pulses and the debounced jump button;
//  produces game state, latched death, freeze for sprite motion, and the score feeding the BCD/7-seg path.
//  Replaces the ad-hoc dead/score logic in the top level with one frame-synchronous FSM.
// PARAMETERS
//  HAZ_CNT      6    number of hazard sprites (5 meteors + hedgehog)
//  SCOREW       8    score width, bits
//  DEATH_FRAMES 60   frames spent in DYING (frog falls)
//  OVER_FRAMES  120  minimum frames in OVER before start is accepted
// PORTS
//  clk_pix    in   1        pixel clock
//  rst_pix    in   1        synchronous reset, active-high
//  frame      in   1        1-cycle pulse at start of frame
//  de         in   1        display-enable, active area
//  player_px  in   1        frog opaque pixel, CLUT-aligned (drawing_t1)
//  hazard_px  in   HAZ_CNT  hazard opaque pixels, CLUT-aligned
//  score_evt  in   HAZ_CNT  1-cycle pulse per hazard respawn (dodged)
//  start      in   1        debounced button level (btn_up)
//  state      out  2        00 ATTRACT, 01 PLAY, 10 DYING, 11 OVER
//  dead       out  1        high in DYING and OVER
//  freeze     out  1        high in ATTRACT and OVER; sprite motion holds
//  score      out  SCOREW   current score, saturating
//  hit_mask   out  HAZ_CNT  hazards that overlapped frog in the fatal frame
// BEHAVIOUR
//  Reset: state=ATTRACT, dead=0, freeze=1, score=0, hit_mask=0, all pending flags and timers 0.
//  Collision: in PLAY, cycle with de && player_px && hazard_px[i] sets hit_pend and hit_mask[i] (sticky OR).
//   Ignored outside PLAY or when de=0. hit_mask cleared on PLAY entry.
//  Start: rising edge of start (registered prev level) sets start_pend; cleared on every state change.
//  All state transitions occur only on the frame cycle; outputs reflect new state the next cycle.
//  ATTRACT -> PLAY  on frame if start_pend; score cleared same edge.
//  PLAY    -> DYING on frame if hit_pend; hit_pend cleared. A hit seen in the frame cycle itself
//   is counted for the next frame.
//  DYING   -> OVER  after DEATH_FRAMES frame pulses (timer loads on entry, decrements per frame, exits at 0).
//  OVER    -> PLAY  on frame if timer expired (OVER_FRAMES) and start_pend; edges before expiry discarded.
//  Score: in PLAY only, score += popcount(score_evt) each cycle; saturates at 2^SCOREW-1.
//   score_evt ignored in other states; score held through DYING/OVER until next PLAY entry.
//  Simultaneous hit + score_evt in same cycle: both take effect.
//  rst_pix mid-game returns to reset values next edge, no pending event survives.
// CONFIGURATION
//  GAME_CTRL_HISCORE_EN defined: extra output hi_score [SCOREW]; reset 0; on DYING->OVER transition
//   hi_score <= max(hi_score, score). Not defined: port absent, no register.
// STRUCTURE
//  Package superfrog_pkg: typedef enum logic [1:0] game_state_t {ATTRACT,PLAY,DYING,OVER};
//   SCOREW default, HAZ_CNT default constants shared with top level.
//  Sub-module frame_timer: load value, decrement on frame, done flag; instantiated once,
//   reused for DEATH_FRAMES and OVER_FRAMES.
// TESTING
//  Reset then start pulse, frame -> state 00 until frame, 01 after; score=0, freeze 1->0.
//  PLAY, overlap player_px & hazard_px[2] with de=1 -> next frame state=10, hit_mask=000100, dead=1.
//  Overlap with de=0, or while in ATTRACT -> no state change, hit_mask=0.
//  PLAY, score_evt=000011 for 1 cycle -> score +2; drive to 255 then more events -> stays 255.
//  DYING 60 frames -> OVER; start at frame 50 of OVER ignored, start after 120 frames -> PLAY, score 0.
//  HISCORE_EN: game 1 ends score 7, game 2 ends score 4 -> hi_score 7; rst_pix mid-PLAY -> all reset values.

Source files
------------

// File: rtl/superfrog_pkg.sv
// Shared types and default sizing for the superfrog game-state path.
package superfrog_pkg;

    typedef enum logic [1:0] {
        ATTRACT = 2'b00,
        PLAY    = 2'b01,
        DYING   = 2'b10,
        OVER    = 2'b11
    } game_state_t;

    localparam int HAZ_CNT_DEF      = 6;
    localparam int SCOREW_DEF       = 8;
    localparam int DEATH_FRAMES_DEF = 60;
    localparam int OVER_FRAMES_DEF  = 120;

    function automatic logic is_dead(input game_state_t s);
        return (s == DYING) || (s == OVER);
    endfunction

    function automatic logic is_frozen(input game_state_t s);
        return (s == ATTRACT) || (s == OVER);
    endfunction

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Frame-counting down-timer: load a value, decrement once per frame pulse, flag when it reaches zero.
module frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count;

    // Load takes priority so a re-arm on the same frame pulse is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/game_ctrl.sv
// Frame-synchronous game-state controller: collision latching, start handling, scoring, death/over timing.
// Optional GAME_CTRL_HISCORE_EN adds a hi_score output updated when a game ends.
module game_ctrl
    import superfrog_pkg::*;
#(
    parameter int HAZ_CNT      = HAZ_CNT_DEF,
    parameter int SCOREW       = SCOREW_DEF,
    parameter int DEATH_FRAMES = DEATH_FRAMES_DEF,
    parameter int OVER_FRAMES  = OVER_FRAMES_DEF
) (
    input  logic                clk_pix,
    input  logic                rst_pix,
    input  logic                frame,
    input  logic                de,
    input  logic                player_px,
    input  logic [HAZ_CNT-1:0]  hazard_px,
    input  logic [HAZ_CNT-1:0]  score_evt,
    input  logic                start,
    output logic [1:0]          state,
    output logic                dead,
    output logic                freeze,
    output logic [SCOREW-1:0]   score,
    output logic [HAZ_CNT-1:0]  hit_mask
`ifdef GAME_CTRL_HISCORE_EN
    ,
    output logic [SCOREW-1:0]   hi_score
`endif
);

    localparam int TMAX = (DEATH_FRAMES > OVER_FRAMES) ? DEATH_FRAMES : OVER_FRAMES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DEATH_VAL = TW'(DEATH_FRAMES - 1);
    localparam logic [TW-1:0] OVER_VAL  = TW'(OVER_FRAMES);

    game_state_t        state_q;
    logic               hit_pend;
    logic               start_prev;
    logic               start_pend;
    logic               start_rise;
    logic [HAZ_CNT-1:0] hit_now;
    logic [SCOREW:0]    evt_cnt;
    logic [SCOREW:0]    score_sum;
    logic [SCOREW-1:0]  score_next;
    logic               timer_load;
    logic [TW-1:0]      timer_val;
    logic               timer_done;
    logic               over_entry;

    assign state      = state_q;
    assign start_rise = start && !start_prev;
    assign hit_now    = {HAZ_CNT{de && player_px}} & hazard_px;
    assign over_entry = (state_q == DYING) && frame && timer_done;

    // The DYING count is loaded one short because the entry frame itself is the first of the fall.
    assign timer_load = frame && (((state_q == PLAY) && hit_pend) || over_entry);
    assign timer_val  = (state_q == PLAY) ? DEATH_VAL : OVER_VAL;

    always_comb begin
        evt_cnt = '0;
        for (int i = 0; i < HAZ_CNT; i++) begin
            evt_cnt = evt_cnt + {{SCOREW{1'b0}}, score_evt[i]};
        end
        score_sum  = {1'b0, score} + evt_cnt;
        score_next = score_sum[SCOREW] ? {SCOREW{1'b1}} : score_sum[SCOREW-1:0];
    end

    frame_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk_pix),
        .rst      (rst_pix),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (frame),
        .done     (timer_done)
    );

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q    <= ATTRACT;
            dead       <= 1'b0;
            freeze     <= 1'b1;
            score      <= '0;
            hit_mask   <= '0;
            hit_pend   <= 1'b0;
            start_prev <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            start_prev <= start;
            // A press while the game-over hold is still running is thrown away.
            if (start_rise && !((state_q == OVER) && !timer_done)) begin
                start_pend <= 1'b1;
            end
            case (state_q)
                ATTRACT, OVER: begin
                    if (frame && start_pend && ((state_q == ATTRACT) || timer_done)) begin
                        state_q    <= PLAY;
                        dead       <= is_dead(PLAY);
                        freeze     <= is_frozen(PLAY);
                        score      <= '0;
                        hit_mask   <= '0;
                        start_pend <= 1'b0;
                    end
                end
                PLAY: begin
                    score <= score_next;
                    if (frame && hit_pend) begin
                        state_q    <= DYING;
                        dead       <= is_dead(DYING);
                        freeze     <= is_frozen(DYING);
                        hit_pend   <= 1'b0;
                        start_pend <= 1'b0;
                    end else if (|hit_now) begin
                        hit_pend <= 1'b1;
                        hit_mask <= hit_mask | hit_now;
                    end
                end
                DYING: begin
                    if (over_entry) begin
                        state_q    <= OVER;
                        dead       <= is_dead(OVER);
                        freeze     <= is_frozen(OVER);
                        start_pend <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ATTRACT;
                end
            endcase
        end
    end

`ifdef GAME_CTRL_HISCORE_EN
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            hi_score <= '0;
        end else if (over_entry && (score > hi_score)) begin
            hi_score <= score;
        end
    end
`else
    // Without the option only the live score is exported.
`endif

endmodule
